// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch front end. Issues one instruction-memory request at a time,
// collects responses into a small FIFO instruction buffer, and hands the buffer
// head to decode. Handles redirects (taken branch / jump) from the branch unit,
// a sticky halt request, and a permanent HALT state that only reset leaves.
//
// Parameters
//   PC_W   program counter / imem byte-address width (must be < 32)
//   DEPTH  instruction-buffer entries, power of two, >= 2
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   PcSel, BrPC         redirect request and its target (BrPC[PC_W-1:0] used)
//   flag_halt           halt request (sticky once seen)
//   Cur_PC              PC of the next fetch
//   imem_req/imem_addr  memory request valid / address (address == Cur_PC)
//   imem_ack/imem_rdata one-cycle response strobe and fetched instruction
//   inst_valid/inst/inst_pc  buffer head; zero when the buffer is empty
//   dec_ready           decode accepts the head
//   halted              fetch has stopped permanently
//   redirect_cnt        accepted-redirect counter, present only when the
//                       macro FETCH_PERF_CNT_EN is defined
//
// FSM states
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | no request outstanding; may issue one this cycle
//   WAIT   | one request outstanding; imem_req held until imem_ack
//   HALT   | fetch stopped; buffer still drains; left only through reset
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int PC_W  = 9,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            PcSel,
    input  logic [31:0]     BrPC,
    input  logic            flag_halt,
    output logic [PC_W-1:0] Cur_PC,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic            inst_valid,
    output logic [31:0]     inst,
    output logic [PC_W-1:0] inst_pc,
    input  logic            dec_ready,
    output logic            halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     redirect_cnt
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [PC_W-1:0] pc_q, pc_nxt;
    logic            stale_q, stale_nxt;
    logic            halt_pend_q, halt_pend_nxt;

    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count_q;
    logic [31:0]     buf_inst [DEPTH];
    logic [PC_W-1:0] buf_pc   [DEPTH];

    logic            redirect;
    logic            halt_req;
    logic            buf_full;
    logic            push;
    logic            pop;
    logic            req_int;

    // Only the low PC_W bits of the redirect target are meaningful.
    logic unused_brpc_hi;
    assign unused_brpc_hi = ^BrPC[31:PC_W];

    // Redirects are ignored once halted.
    assign redirect   = PcSel && (state != S_HALT);
    assign halt_req   = halt_pend_q || flag_halt;
    assign buf_full   = (count_q == CW'(DEPTH));
    assign inst_valid = (count_q != '0);
    // A redirect flushes the buffer, so a same-cycle pop is meaningless.
    assign pop        = inst_valid && dec_ready && !redirect;

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc_q;
        stale_nxt     = stale_q;
        halt_pend_nxt = halt_pend_q;
        req_int       = 1'b0;
        push          = 1'b0;

        if ((state != S_HALT) && flag_halt) begin
            halt_pend_nxt = 1'b1;
        end

        case (state)
            S_IDLE: begin
                if (halt_req) begin
                    state_nxt = S_HALT;
                end else if (!redirect && !buf_full) begin
                    // No request in a redirect cycle: the address is about to
                    // change and a request to the old PC would only be stale.
                    req_int   = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                req_int = 1'b1;
                if (imem_ack) begin
                    push = !stale_q && !redirect;
                    if (push) begin
                        pc_nxt = pc_q + PC_W'(4);
                    end
                    stale_nxt = 1'b0;
                    state_nxt = halt_req ? S_HALT : S_IDLE;
                end else if (redirect) begin
                    // The response still in flight belongs to the old path.
                    stale_nxt = 1'b1;
                end
            end
            S_HALT: begin
                state_nxt = S_HALT;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        if (redirect) begin
            pc_nxt = BrPC[PC_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pc_q        <= '0;
            stale_q     <= 1'b0;
            halt_pend_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc_q        <= pc_nxt;
            stale_q     <= stale_nxt;
            halt_pend_q <= halt_pend_nxt;
        end
    end

    // Buffer bookkeeping. Push and pop never collide with a full buffer since
    // at most one request is outstanding and none is issued when full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (redirect) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (!push && pop) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    // Storage needs no reset: it is only observed through count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_inst[wr_ptr] <= imem_rdata;
            buf_pc[wr_ptr]   <= pc_q;
        end
    end

    // Gating with rst_n keeps the request low for the whole reset assertion,
    // even though the reset state itself would otherwise request.
    assign imem_req  = req_int && rst_n;
    assign Cur_PC    = pc_q;
    assign imem_addr = pc_q;
    assign inst      = inst_valid ? buf_inst[rd_ptr] : '0;
    assign inst_pc   = inst_valid ? buf_pc[rd_ptr]   : '0;
    assign halted    = (state == S_HALT);

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] redirect_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_cnt_q <= '0;
        end else if (redirect) begin
            redirect_cnt_q <= redirect_cnt_q + 32'd1;
        end
    end

    assign redirect_cnt = redirect_cnt_q;
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_W, default 9: width of the program counter and instruction-memory byte address.
REQ-002 Parameter DEPTH, default 2: instruction-buffer entries; a power of two, at least 2.
REQ-003 Port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port PcSel, input, 1: redirect request, taken branch or jump, from the branch unit.
REQ-006 Port BrPC, input, 32: redirect target; bits [PC_W-1:0] are used.
REQ-007 Port flag_halt, input, 1: halt request.
REQ-008 Port Cur_PC, output, PC_W: PC of the next fetch; also fed to the branch unit.
REQ-009 Port imem_req, output, 1: instruction-memory request valid.
REQ-010 Port imem_addr, output, PC_W: request address; always equals Cur_PC.
REQ-011 Port imem_ack, input, 1: memory response strobe, one cycle, carrying imem_rdata.
REQ-012 Port imem_rdata, input, 32: fetched instruction.
REQ-013 Port inst_valid, output, 1: buffer head is valid.
REQ-014 Port inst, output, 32: buffer-head instruction.
REQ-015 Port inst_pc, output, PC_W: buffer-head PC.
REQ-016 Port dec_ready, input, 1: decode accepts the head.
REQ-017 Port halted, output, 1: fetch has stopped permanently.

Function
REQ-018 FSM has three states:
- IDLE: no request outstanding.
- WAIT: request outstanding.
- HALT: fetch stopped.
REQ-019 IDLE->WAIT when buffer count < DEPTH and no halt is pending; imem_req is high in that cycle and in every WAIT cycle until imem_ack.
REQ-020 imem_addr is held stable while imem_req is high, unless a redirect occurs.
REQ-021 Response handling, WAIT with imem_ack:
- Push {Cur_PC, imem_rdata} into the buffer.
- Cur_PC <= Cur_PC + 4, modulo 2^PC_W, wrapping to 0.
- Return to IDLE.
REQ-022 Pushed data appears on inst_valid/inst/inst_pc in the cycle after imem_ack (1-cycle latency).
REQ-023 Pop occurs when inst_valid && dec_ready; push and pop in the same cycle leave the count unchanged.
REQ-024 Full buffer: no new request is issued; at most one request is outstanding, so a response never arrives when the buffer is full.
REQ-025 Empty buffer: inst_valid=0, inst=0, inst_pc=0.
REQ-026 Redirect, PcSel=1 in cycle N:
- Buffer cleared.
- Cur_PC <= BrPC[PC_W-1:0] at end of N.
- A same-cycle pop is ignored.
REQ-027 Redirect while in WAIT: the outstanding response is marked stale and discarded on arrival with no push and no PC increment; a new request issues only after that ack.
REQ-028 Redirect and ack in the same cycle: the ack data is discarded and the redirect target is applied.
REQ-029 Halt: flag_halt=1 sets a sticky pending flag and no new requests issue.
- Pending in IDLE -> HALT next cycle.
- Pending in WAIT -> the outstanding response is completed normally, then HALT.
REQ-030 HALT state: imem_req=0, halted=1, Cur_PC frozen; PcSel is ignored; the buffer still drains to decode; exit only by reset.
REQ-031 PcSel and flag_halt in the same cycle: the redirect is applied first, then halt proceeds per REQ-029.

Reset
REQ-032 While rst_n=0, asynchronously:
- state=IDLE.
- Cur_PC=0.
- Buffer empty, stale and pending flags cleared.
- imem_req=0, inst_valid=0, inst=0, inst_pc=0, halted=0.
REQ-033 Reset asserted during WAIT abandons the request; an imem_ack in the first cycle after reset release is ignored.

Configuration
REQ-034 Macro FETCH_PERF_CNT_EN defined adds output port redirect_cnt, 32 bits, reset to 0, incremented on each accepted redirect and wrapping.
REQ-035 Without FETCH_PERF_CNT_EN the port and its counter do not exist; all other behaviour is identical.

Verification
REQ-036 Sequential run: ack each request after 1 cycle, dec_ready=1 -> imem_addr sequence 0x000, 0x004, 0x008, and inst_pc matches each instruction.
REQ-037 Back-pressure: dec_ready=0, DEPTH=2 -> exactly 2 pushes, then imem_req stays 0; raising dec_ready resumes at 0x008.
REQ-038 Redirect mid-WAIT: PcSel=1 with BrPC=0x40 while the request to 0x004 is outstanding -> that ack's data is dropped, buffer empty, next request to 0x040.
REQ-039 Halt: flag_halt pulse during WAIT -> the outstanding ack is pushed, then halted=1, imem_req=0, and a later PcSel has no effect.
REQ-040 Wrap and reset: Cur_PC=0x1FC with an ack -> Cur_PC=0x000; rst_n low mid-WAIT -> all outputs 0 immediately.
